debug_sequencer: RTL and testbench
==================================

# debug_sequencer

UART-driven sequencer that owns the pipeline enable of the DLX/MIPS core. It decodes single-byte host commands from the UART receiver to load instruction memory, run to a HALT, single-step and report the PC. Every pipeline register, the PC and the control-unit decode stage advance only when this block grants `pipe_en`. It sits between the UART RX/TX modules and the core's instruction-fetch and pipeline-register enables.

## Interface
Parameters:
- `IMEM_ADDR_W`, default 8: instruction-memory word-address width; at most 256 words per load.
- `PC_W`, default 32: width of the reported PC.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte; valid only while `rx_valid` is high.
- `rx_valid`  in  1  one-cycle strobe per received byte.
- `tx_data`  out  8  byte to transmit; held stable from `tx_start` until `tx_busy` falls.
- `tx_start`  out  1  one-cycle transmit request.
- `tx_busy`  in  1  transmitter busy; rises the cycle after `tx_start`.
- `pipe_en`  out  1  global enable for the PC and all pipeline registers.
- `pipe_clr`  out  1  synchronous clear of the PC and pipeline registers.
- `imem_we`  out  1  instruction-memory write strobe.
- `imem_addr`  out  `IMEM_ADDR_W`  word address for the write.
- `imem_wdata`  out  32  instruction word to write.
- `cpu_halt`  in  1  high while a HALT opcode (6'b111111) is in WB.
- `pc_in`  in  `PC_W`  current fetch PC.

## Operation
- Reset values: all outputs 0; state IDLE; `imem_addr` 0.
- The block decodes command bytes only in IDLE:
  - 'L' (0x4C) goes to LOAD_LEN and asserts `pipe_clr` through the whole load.
  - 'R' (0x52) goes to RUN.
  - 'S' (0x53) goes to STEP.
  - Any other byte goes to REPLY with byte '?' (0x3F).
- LOAD_LEN: the next byte is the word count N, where 0 means 256.
  - `imem_addr` resets to 0.
  - The state moves to LOAD_DATA.
- LOAD_DATA: bytes arrive MSB first and are shifted into a 32-bit assembly register.
  - On every 4th byte, `imem_we` pulses for one cycle with the assembled word, then `imem_addr` increments.
  - After N words the state moves to REPLY with 'K' (0x4B) and `pipe_clr` drops.
- RUN: `pipe_en` is held at 1.
  - The state leaves RUN on `cpu_halt`=1, or on `rx_valid` with byte 'H' (0x48).
  - `pipe_en` drops in the same cycle the exit condition is sampled, then the state moves to REPORT.
  - Other bytes received during RUN are discarded.
- STEP: `pipe_en`=1 for exactly one cycle, then the state moves to REPORT.
- REPORT: the block samples `pc_in` into a shadow register on entry and sends it MSB first, `PC_W`/8 bytes. It then returns to IDLE.
- REPLY: sends one byte, then returns to IDLE.
- Bytes received in REPLY, REPORT or LOAD_LEN are ignored, except that LOAD_LEN consumes the length byte.

## Timing
- Command byte to `pipe_en` rising: 1 cycle after the `rx_valid` cycle.
- Transmit handshake:
  - `tx_start` is issued only when `tx_busy`=0.
  - The next byte waits for `tx_busy` to be seen high, then low.
  - Each byte costs at least 3 cycles plus the UART frame time.
- `imem_we` is asserted in the cycle after the 4th byte's `rx_valid`.
- `cpu_halt` already high on entry to RUN: exactly 1 cycle of `pipe_en`, then REPORT. This gives a deterministic run past a stale HALT.
- `cpu_halt` and 'H' in the same cycle: a single exit and a single report.
- Reset asserted mid-load or mid-run:
  - All outputs clear immediately.
  - A partially assembled word is discarded.
  - Memory already written is left as is.
- `imem_addr` wraps at 2^`IMEM_ADDR_W`. With N=256 and the default width, the last word goes to address 255.

## Configuration
- `DEBUG_CYCLE_COUNT_EN` defined:
  - A 32-bit counter increments on every cycle with `pipe_en`=1 and saturates at 0xFFFFFFFF.
  - The counter clears on 'L' and on reset.
  - REPORT sends the PC bytes, then the 4 counter bytes MSB first.
- `DEBUG_CYCLE_COUNT_EN` undefined: no counter exists and REPORT sends the PC only.

## Structure
- The shared package `debug_pkg` holds:
  - command codes 'L', 'R', 'S', 'H';
  - reply codes 'K', '?';
  - the HALT opcode 6'b111111;
  - the state-encoding localparams IDLE, LOAD_LEN, LOAD_DATA, RUN, STEP, REPORT, REPLY.
- One sub-module, `debug_tx_seq`, serializes a word of up to 64 bits and a byte count into `tx_start`/`tx_data`. It asserts `done` when finished. REPORT and REPLY both use it.

## Test plan
- 'L', 0x02, then 00 00 00 20 00 00 00 08 → `imem_we` at addresses 0 and 1 with 0x00000020 and 0x00000008. `pipe_clr` stays high throughout, then TX sends 0x4B.
- 'S' with `pc_in`=0x00000004 → `pipe_en` high for exactly 1 cycle. TX sends 00 00 00 04.
- 'R', with `cpu_halt` forced high 10 cycles later and `pc_in`=0x0000002C → 10 `pipe_en` cycles. TX sends 00 00 00 2C. With the macro defined, TX then sends 00 00 00 0A.
- 'R', then 'H' on cycle 5 → `pipe_en` falls in the 'H' cycle and one report is sent. A following 'X' returns 0x3F.
- `rst_n` pulsed low after 6 of 8 load bytes → outputs clear and the state is IDLE. A fresh 'S' behaves exactly as in scenario 2.
- `tx_busy` held high for 50 cycles → `tx_start` is not reasserted until `tx_busy` falls, and no byte is lost.

Source files
------------

// File: rtl/debug_pkg.sv
// debug_pkg: shared constants for the debug sequencer.
//   - Host command codes: 'L' (load), 'R' (run), 'S' (step), 'H' (halt a run).
//   - Reply codes: 'K' (load complete), '?' (unknown command).
//   - The core's HALT opcode.
//   - State encodings for the sequencer and for its transmit serializer.
package debug_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_HALT = 8'h48;

  localparam logic [7:0] RPL_OK   = 8'h4B;
  localparam logic [7:0] RPL_ERR  = 8'h3F;

  // Opcode the core decodes as HALT; cpu_halt is high while it sits in WB.
  localparam logic [5:0] HALT_OPCODE = 6'b111111;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_LEN,
    LOAD_DATA,
    RUN,
    STEP,
    REPORT,
    REPLY
  } seq_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_WAIT_HI,
    TX_WAIT_LO
  } tx_state_e;

endpackage

// File: rtl/debug_tx_seq.sv
// debug_tx_seq: serializes up to 8 bytes onto a UART transmitter, MSB first.
// The word is left-aligned in word_i (first byte in bits 63:56).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start_i         one-cycle request; word_i/nbytes_i are captured here
//   word_i[63:0]    left-aligned payload
//   nbytes_i[3:0]   number of bytes to send (1..8)
//   tx_busy_i       transmitter busy, rises the cycle after tx_start_o
//   tx_data_o[7:0]  current byte, stable until tx_busy_i falls
//   tx_start_o      one-cycle transmit request, only while tx_busy_i is low
//   done_o          one-cycle pulse when the last byte has left
module debug_tx_seq
  import debug_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [63:0] word_i,
  input  logic [3:0]  nbytes_i,
  input  logic        tx_busy_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_start_o,
  output logic        done_o
);

  tx_state_e   state_q, state_d;
  logic [63:0] shift_q, shift_d;
  logic [3:0]  cnt_q, cnt_d;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values that were present before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    tx_start_o = 1'b0;
    done_o     = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        if (start_i) begin
          shift_d = word_i;
          cnt_d   = nbytes_i;
          state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        if (!tx_busy_i) begin
          tx_start_o = 1'b1;
          state_d    = TX_WAIT_HI;
        end
      end
      // Busy must be seen high before its fall counts as end of frame.
      TX_WAIT_HI: begin
        if (tx_busy_i) state_d = TX_WAIT_LO;
      end
      TX_WAIT_LO: begin
        if (!tx_busy_i) begin
          // Shift only after the frame is out, so tx_data_o stays stable.
          shift_d = {shift_q[55:0], 8'h00};
          cnt_d   = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            done_o  = 1'b1;
            state_d = TX_IDLE;
          end else begin
            state_d = TX_SEND;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign tx_data_o = shift_q[63:56];

endmodule

// File: rtl/debug_sequencer.sv
// debug_sequencer: UART command sequencer owning the core's pipeline enable.
// Host commands decoded in IDLE: 'L' load imem, 'R' run to HALT or 'H',
// 'S' single step; run and step end with a PC report, load ends with 'K',
// anything else is answered with '?'.
// Optional build macro DEBUG_CYCLE_COUNT_EN: adds a saturating 32-bit count
// of pipe_en cycles (cleared on 'L' and reset), appended to every report.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   rx_data, rx_valid      received byte and its one-cycle strobe
//   tx_data, tx_start      byte to transmit and its one-cycle request
//   tx_busy                transmitter busy
//   pipe_en, pipe_clr      pipeline/PC enable and synchronous clear
//   imem_we, imem_addr,
//   imem_wdata             instruction-memory write port
//   cpu_halt               HALT opcode in WB
//   pc_in                  current fetch PC (PC_W a multiple of 8;
//                          at most 32 when the cycle counter is built in)
module debug_sequencer
  import debug_pkg::*;
#(
  parameter int IMEM_ADDR_W = 8,
  parameter int PC_W        = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic                   pipe_en,
  output logic                   pipe_clr,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [31:0]            imem_wdata,
  input  logic                   cpu_halt,
  input  logic [PC_W-1:0]        pc_in
);

  seq_state_e             state_q, state_d;
  logic                   entry_q;
  logic [8:0]             words_q, words_d;
  logic [1:0]             bidx_q, bidx_d;
  logic [31:0]            asm_q, asm_d;
  logic [IMEM_ADDR_W-1:0] addr_q, addr_d;
  logic                   we_q, we_d;
  logic [7:0]             reply_q, reply_d;

  logic                   tx_go, tx_done;
  logic [63:0]            tx_word, rep_word;
  logic [3:0]             tx_n;
  logic                   run_exit;

`ifdef DEBUG_CYCLE_COUNT_EN
  localparam logic [3:0] REP_BYTES = 4'(PC_W / 8 + 4);
  logic [31:0] cyc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                            cyc_q <= '0;
    else if (state_q == IDLE && rx_valid && rx_data == CMD_LOAD) cyc_q <= '0;
    else if (pipe_en && cyc_q != 32'hFFFF_FFFF)            cyc_q <= cyc_q + 32'd1;
  end

  assign rep_word = 64'({pc_in, cyc_q}) << (32 - PC_W);
`else
  localparam logic [3:0] REP_BYTES = 4'(PC_W / 8);
  assign rep_word = 64'(pc_in) << (64 - PC_W);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      entry_q <= 1'b0;
      words_q <= '0;
      bidx_q  <= '0;
      asm_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      reply_q <= '0;
    end else begin
      state_q <= state_d;
      // High in the first cycle of every state: starts a transmission and
      // masks a stale cpu_halt on the first RUN cycle.
      entry_q <= (state_d != state_q);
      words_q <= words_d;
      bidx_q  <= bidx_d;
      asm_q   <= asm_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      reply_q <= reply_d;
    end
  end

  assign run_exit = (rx_valid && rx_data == CMD_HALT) || (cpu_halt && !entry_q);

  always_comb begin
    state_d = state_q;
    words_d = words_q;
    bidx_d  = bidx_q;
    asm_d   = asm_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    reply_d = reply_q;
    pipe_en = 1'b0;
    tx_go   = 1'b0;
    tx_word = {reply_q, 56'h0};
    tx_n    = 4'd1;
    unique case (state_q)
      IDLE: begin
        if (rx_valid) begin
          unique case (rx_data)
            CMD_LOAD: state_d = LOAD_LEN;
            CMD_RUN:  state_d = RUN;
            CMD_STEP: state_d = STEP;
            default: begin
              reply_d = RPL_ERR;
              state_d = REPLY;
            end
          endcase
        end
      end
      LOAD_LEN: begin
        if (rx_valid) begin
          words_d = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
          addr_d  = '0;
          bidx_d  = '0;
          state_d = LOAD_DATA;
        end
      end
      LOAD_DATA: begin
        // The write cycle follows the 4th byte; the address moves after it,
        // and the block stays here until the last write is done.
        if (we_q) begin
          addr_d = addr_q + IMEM_ADDR_W'(1);
          if (words_q == 9'd0) begin
            reply_d = RPL_OK;
            state_d = REPLY;
          end
        end
        if (rx_valid && words_q != 9'd0) begin
          asm_d  = {asm_q[23:0], rx_data};
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            we_d    = 1'b1;
            words_d = words_q - 9'd1;
          end
        end
      end
      RUN: begin
        if (run_exit) state_d = REPORT;
        else          pipe_en = 1'b1;
      end
      STEP: begin
        pipe_en = 1'b1;
        state_d = REPORT;
      end
      REPORT: begin
        // pc_in is captured by the serializer on its start cycle.
        tx_go   = entry_q;
        tx_word = rep_word;
        tx_n    = REP_BYTES;
        if (tx_done) state_d = IDLE;
      end
      REPLY: begin
        tx_go = entry_q;
        if (tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pipe_clr   = (state_q == LOAD_LEN) || (state_q == LOAD_DATA);
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = asm_q;

  debug_tx_seq u_tx (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (tx_go),
    .word_i     (tx_word),
    .nbytes_i   (tx_n),
    .tx_busy_i  (tx_busy),
    .tx_data_o  (tx_data),
    .tx_start_o (tx_start),
    .done_o     (tx_done)
  );

endmodule

// File: tb/tb_debug_sequencer.sv
// Scoreboard bench for debug_sequencer: stimulus pushes expected TX bytes and
// imem writes into queues; monitors pop and compare when the DUT presents them.
module tb_debug_sequencer;

  localparam int FRAME = 6;

  logic        clk, rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start, tx_busy;
  logic        pipe_en, pipe_clr, imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_halt;
  logic [31:0] pc_in;

  debug_sequencer #(.IMEM_ADDR_W(8), .PC_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .pipe_en    (pipe_en),
    .pipe_clr   (pipe_clr),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_halt   (cpu_halt),
    .pc_in      (pc_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART transmitter model: busy rises the cycle after tx_start for FRAME cycles.
  logic model_busy, force_busy;
  int   frame_cnt;
  assign tx_busy = model_busy | force_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_busy <= 1'b0;
      frame_cnt  <= 0;
    end else if (tx_start) begin
      model_busy <= 1'b1;
      frame_cnt  <= FRAME;
    end else if (frame_cnt > 1) begin
      frame_cnt  <= frame_cnt - 1;
    end else begin
      frame_cnt  <= 0;
      model_busy <= 1'b0;
    end
  end

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } we_t;

  logic [7:0]  exp_tx[$];
  we_t         exp_we[$];
  int          n_cmp, n_fail;
  int          pe_cnt, tx_starts;
  int unsigned exp_cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event occurred with nothing expected", name);
  endtask

  // TX monitor: protocol, byte value and hold-stability checks.
  logic [7:0] tx_hold;
  logic       prev_busy, tx_pending;
  initial begin
    prev_busy  = 1'b0;
    tx_pending = 1'b0;
    tx_hold    = '0;
  end
  always @(negedge clk) begin
    if (tx_start) begin
      tx_starts++;
      check("tx_start_while_busy", 64'(tx_busy), 64'd0);
      if (exp_tx.size() == 0) flag_fail("tx_extra_byte");
      else check("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
      tx_hold    = tx_data;
      tx_pending = 1'b1;
    end
    if (prev_busy && !tx_busy && tx_pending) begin
      check("tx_data_stable", 64'(tx_data), 64'(tx_hold));
      tx_pending = 1'b0;
    end
    prev_busy = tx_busy;
  end

  // Instruction-memory write monitor.
  always @(negedge clk) begin
    if (imem_we) begin
      if (exp_we.size() == 0) begin
        flag_fail("imem_extra_write");
      end else begin
        we_t e;
        e = exp_we.pop_front();
        check("imem_addr", 64'(imem_addr), 64'(e.addr));
        check("imem_wdata", 64'(imem_wdata), 64'(e.data));
        check("pipe_clr_at_write", 64'(pipe_clr), 64'd1);
      end
    end
    if (pipe_en) pe_cnt++;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic push_report(input logic [31:0] pc, input logic [31:0] cyc);
    for (int i = 3; i >= 0; i--) exp_tx.push_back(pc[8*i +: 8]);
`ifdef DEBUG_CYCLE_COUNT_EN
    for (int i = 3; i >= 0; i--) exp_tx.push_back(cyc[8*i +: 8]);
`endif
  endtask

  // Waits until all expected traffic is seen and the link is quiet.
  task automatic wait_idle(input string name, input int max_cycles);
    int streak;
    streak = 0;
    for (int i = 0; i < max_cycles && streak < 4; i++) begin
      @(negedge clk);
      if (!tx_start && !tx_busy && exp_tx.size() == 0 && exp_we.size() == 0) streak++;
      else streak = 0;
    end
    if (streak < 4) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: tx left %0d, we left %0d, expected 0", name,
               exp_tx.size(), exp_we.size());
      exp_tx.delete();
      exp_we.delete();
    end
  endtask

  task automatic do_step(input logic [31:0] pc);
    pc_in   = pc;
    exp_cyc = exp_cyc + 1;
    push_report(pc, exp_cyc);
    pe_cnt = 0;
    @(posedge clk); #1;
    rx_data  = 8'h53;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(negedge clk);
    check("step_pipe_en_rise", 64'(pipe_en), 64'd1);
    wait_idle("step", 400);
    check("step_pipe_en_cycles", 64'(pe_cnt), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w8;
    int starts0;
    n_cmp = 0; n_fail = 0; pe_cnt = 0; tx_starts = 0; exp_cyc = 0;
    rx_data = '0; rx_valid = 1'b0; cpu_halt = 1'b0; pc_in = '0; force_busy = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {tx_start, tx_data, pipe_en, pipe_clr, imem_we, imem_addr, imem_wdata},
          64'd0);
    rst_n = 1'b1;

    // Load two words.
    exp_cyc = 0;
    exp_we.push_back('{8'd0, 32'h0000_0020});
    exp_we.push_back('{8'd1, 32'h0000_0008});
    exp_tx.push_back(8'h4B);
    pe_cnt = 0;
    send_byte(8'h4C, 2);
    send_byte(8'h02, 2);
    check("load_pipe_clr_high", 64'(pipe_clr), 64'd1);
    send_byte(8'h00, 2); send_byte(8'h00, 2); send_byte(8'h00, 2); send_byte(8'h20, 2);
    send_byte(8'h00, 2); send_byte(8'h00, 2); send_byte(8'h00, 2); send_byte(8'h08, 2);
    wait_idle("load", 400);
    check("load_pipe_clr_after", 64'(pipe_clr), 64'd0);
    check("load_no_pipe_en", 64'(pe_cnt), 64'd0);
    check("load_final_addr", 64'(imem_addr), 64'd2);

    // Single step.
    do_step(32'h0000_0004);

    // Run with cpu_halt raised after 10 enabled cycles.
    pc_in   = 32'h0000_002C;
    exp_cyc = exp_cyc + 10;
    push_report(32'h0000_002C, exp_cyc);
    pe_cnt = 0;
    @(posedge clk); #1; rx_data = 8'h52; rx_valid = 1'b1;
    @(posedge clk); #1; rx_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 cpu_halt = 1'b1;
    wait_idle("run_halt", 400);
    check("run_halt_pipe_en_cycles", 64'(pe_cnt), 64'd10);

    // Run with a stale HALT: exactly one enabled cycle.
    exp_cyc = exp_cyc + 1;
    push_report(32'h0000_002C, exp_cyc);
    pe_cnt = 0;
    send_byte(8'h52, 0);
    wait_idle("run_stale", 400);
    check("run_stale_pipe_en_cycles", 64'(pe_cnt), 64'd1);
    cpu_halt = 1'b0;

    // Run stopped by 'H' on cycle 5; a stray byte during RUN is discarded.
    pc_in   = 32'h0000_0030;
    exp_cyc = exp_cyc + 4;
    push_report(32'h0000_0030, exp_cyc);
    pe_cnt = 0;
    @(posedge clk); #1; rx_data = 8'h52; rx_valid = 1'b1;
    @(posedge clk); #1; rx_valid = 1'b0;
    @(posedge clk); #1; rx_data = 8'h51; rx_valid = 1'b1;
    @(posedge clk); #1; rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1; rx_data = 8'h48; rx_valid = 1'b1;
    @(negedge clk);
    check("run_h_pipe_en_fall", 64'(pipe_en), 64'd0);
    @(posedge clk); #1; rx_valid = 1'b0;
    wait_idle("run_h", 400);
    check("run_h_pipe_en_cycles", 64'(pe_cnt), 64'd4);
    exp_tx.push_back(8'h3F);
    send_byte(8'h58, 0);
    wait_idle("unknown_cmd", 400);

    // 'H' and cpu_halt in the same cycle: one exit, one report.
    pc_in   = 32'h0000_0034;
    exp_cyc = exp_cyc + 2;
    push_report(32'h0000_0034, exp_cyc);
    pe_cnt = 0;
    @(posedge clk); #1; rx_data = 8'h52; rx_valid = 1'b1;
    @(posedge clk); #1; rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1; rx_data = 8'h48; rx_valid = 1'b1; cpu_halt = 1'b1;
    @(posedge clk); #1; rx_valid = 1'b0; cpu_halt = 1'b0;
    wait_idle("run_h_and_halt", 400);
    check("run_h_and_halt_pipe_en_cycles", 64'(pe_cnt), 64'd2);

    // Reset after 6 of 8 load bytes, then a fresh step.
    exp_cyc = 0;
    exp_we.push_back('{8'd0, 32'h1122_3344});
    send_byte(8'h4C, 2);
    send_byte(8'h02, 2);
    send_byte(8'h11, 2); send_byte(8'h22, 2); send_byte(8'h33, 2);
    send_byte(8'h44, 2); send_byte(8'h55, 2); send_byte(8'h66, 2);
    check("midload_pipe_clr", 64'(pipe_clr), 64'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("midload_reset_outputs", {tx_start, tx_data, pipe_en, pipe_clr, imem_we, imem_addr},
          64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    exp_cyc = 0;
    do_step(32'h0000_0004);

    // Transmitter held busy for 50 cycles: no request until it frees up.
    force_busy = 1'b1;
    exp_tx.push_back(8'h3F);
    starts0 = tx_starts;
    send_byte(8'h5A, 0);
    repeat (50) @(posedge clk);
    check("busy_hold_no_start", 64'(tx_starts - starts0), 64'd0);
    #1 force_busy = 1'b0;
    wait_idle("busy_hold", 400);

    // Length 0 loads 256 words; the last lands at 255 and the address wraps.
    exp_cyc = 0;
    for (int i = 0; i < 256; i++) begin
      w8 = 8'(i);
      exp_we.push_back('{w8, {w8, ~w8, 8'h5A, w8 ^ 8'hA5}});
    end
    exp_tx.push_back(8'h4B);
    send_byte(8'h4C, 1);
    send_byte(8'h00, 1);
    for (int i = 0; i < 256; i++) begin
      w8 = 8'(i);
      send_byte(w8, 1);
      send_byte(~w8, 1);
      send_byte(8'h5A, 1);
      send_byte(w8 ^ 8'hA5, 1);
    end
    wait_idle("load_256", 400);
    check("load_256_addr_wrap", 64'(imem_addr), 64'd0);
    check("load_256_pipe_clr_after", 64'(pipe_clr), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
